// File: rtl/p_box_inv_seq.sv
// p_box_inv_seq: sequential inverse 32-bit P-box, BITS_PER_CYCLE result bits per clock.
// Optional macro PBOX_BIDIR_EN adds a fwd port that selects the forward table per word.
module p_box_inv_seq #(
    parameter int BITS_PER_CYCLE = 4
) (
    input  logic        clk,
    input  logic        rst,
`ifdef PBOX_BIDIR_EN
    input  logic        fwd,
`endif
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] In32,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] Out32
);
    localparam int STEPS = 32 / BITS_PER_CYCLE;
    localparam int SW = STEPS > 1 ? $clog2(STEPS) : 1;
    localparam logic [SW-1:0] LAST = SW'(STEPS - 1);
    localparam logic [31:0] SLICE = {32{1'b1}} >> (32 - BITS_PER_CYCLE);
    localparam int INV_TABLE [32] = '{27, 8, 28, 29, 11, 6, 1, 9, 10, 7, 3, 4, 12, 13, 14, 0,
                                      16, 15, 20, 18, 2, 30, 5, 19, 31, 17, 21, 23, 22, 24, 26, 25};

    if (!(BITS_PER_CYCLE inside {1, 2, 4, 8, 16, 32})) begin : g_bad_bpc
        $error("BITS_PER_CYCLE must be 1, 2, 4, 8, 16 or 32");
    end

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t        state, state_next;
    logic [SW-1:0] step;
    logic [31:0]   cap, res, perm, mask, inv_word;
    logic          accept;

    for (genvar j = 0; j < 32; j++) begin : g_inv
        assign inv_word[j] = cap[INV_TABLE[j]];
    end

`ifdef PBOX_BIDIR_EN
    localparam int FWD_TABLE [32] = '{15, 6, 20, 10, 11, 22, 5, 9, 1, 7, 8, 4, 12, 13, 14, 17,
                                      16, 25, 19, 23, 18, 26, 28, 27, 29, 31, 30, 0, 2, 3, 21, 24};
    logic        fwd_q;
    logic [31:0] fwd_word;
    for (genvar j = 0; j < 32; j++) begin : g_fwd
        assign fwd_word[j] = cap[FWD_TABLE[j]];
    end
    // direction is latched at accept so the whole word uses one table
    always_ff @(posedge clk) begin
        if (rst) fwd_q <= 1'b0;
        else if (accept) fwd_q <= fwd;
    end
    assign perm = fwd_q ? fwd_word : inv_word;
`else
    assign perm = inv_word;
`endif

    assign accept    = state == IDLE && in_valid;
    assign in_ready  = state == IDLE;
    assign out_valid = state == DONE;
    assign Out32     = res;
    assign mask      = SLICE << (32'(step) * BITS_PER_CYCLE);

    // next-state: accept -> walk STEPS slices -> hold until downstream takes it
    always_comb begin
        state_next = state;
        if (accept) state_next = BUSY;
        else if (state == BUSY && step == LAST) state_next = DONE;
        else if (state == DONE && out_ready) state_next = IDLE;
    end

    // capture on accept, then fill one result slice per BUSY cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            step  <= '0;
            cap   <= '0;
            res   <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cap  <= In32;
                res  <= '0;
                step <= '0;
            end else if (state == BUSY) begin
                res <= (res & ~mask) | (perm & mask);
                if (step != LAST) step <= step + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_p_box_inv_seq.sv
// tb_p_box_inv_seq: directed scoreboard bench for p_box_inv_seq.
module tb_p_box_inv_seq;
    parameter int BPC = 4;
    localparam int STEPS = 32 / BPC;
    localparam int LAT = STEPS + 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        fwd = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] In32 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Out32;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] q[$];

    int INV[32] = '{27, 8, 28, 29, 11, 6, 1, 9, 10, 7, 3, 4, 12, 13, 14, 0,
                    16, 15, 20, 18, 2, 30, 5, 19, 31, 17, 21, 23, 22, 24, 26, 25};
    int FWD[32] = '{15, 6, 20, 10, 11, 22, 5, 9, 1, 7, 8, 4, 12, 13, 14, 17,
                    16, 25, 19, 23, 18, 26, 28, 27, 29, 31, 30, 0, 2, 3, 21, 24};

    always #5 clk = ~clk;

    p_box_inv_seq #(.BITS_PER_CYCLE(BPC)) dut (
        .clk(clk),
        .rst(rst),
`ifdef PBOX_BIDIR_EN
        .fwd(fwd),
`endif
        .in_valid(in_valid),
        .in_ready(in_ready),
        .In32(In32),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .Out32(Out32)
    );

    function automatic logic [31:0] model(input logic [31:0] w, input logic f);
        logic [31:0] r;
        for (int j = 0; j < 32; j++) r[j] = w[f ? FWD[j] : INV[j]];
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    // drive one word; returns at the falling edge after the accept edge
    task automatic send(input logic [31:0] w, input logic f, input logic [31:0] exp);
        int n;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("send_ready", 32'(in_ready), 32'd1);
        In32 = w;
        fwd = f;
        in_valid = 1'b1;
        @(posedge clk);
        q.push_back(exp);
        @(negedge clk);
        in_valid = 1'b0;
        In32 = $urandom;
        fwd = ~f;
        check("busy_in_ready", 32'(in_ready), 32'd0);
    endtask

    // wait for out_valid counting edges from accept, then score the result
    task automatic wait_done(input string tag);
        int lat;
        logic [31:0] exp;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        check({tag, "_sb"}, 32'(q.size() != 0), 32'd1);
        exp = q.size() != 0 ? q.pop_front() : 32'hxxxx_xxxx;
        check(tag, Out32, exp);
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check("rel_out_valid", 32'(out_valid), 32'd0);
        check("rel_in_ready", 32'(in_ready), 32'd1);
    endtask

    initial begin
        int k;
        int seen;
        logic [31:0] x;
        logic [31:0] exp_bp;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out", Out32, 32'h0);

        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        out_ready = 1'b0;
        check("idle_ready_in_ready", 32'(in_ready), 32'd1);
        check("idle_ready_out_valid", 32'(out_valid), 32'd0);

        send(32'h0000_0001, 1'b0, 32'h0000_8000);
        wait_done("bit0");
        release_out();
        send(32'h8000_0000, 1'b0, 32'h0100_0000);
        wait_done("bit31");
        release_out();
        send(32'h0001_7000, 1'b0, 32'h0001_7000);
        wait_done("fixed");
        release_out();
        send(32'hFFFF_FFFF, 1'b0, 32'hFFFF_FFFF);
        wait_done("ones");
        release_out();
        x = $urandom;
        send(x, 1'b0, model(x, 1'b0));
        wait_done("rand");
        release_out();

        exp_bp = model(32'h1234_5678, 1'b0);
        send(32'h1234_5678, 1'b0, exp_bp);
        wait_done("bp");
        In32 = 32'hDEAD_BEEF;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_out", Out32, exp_bp);
            check("bp_out_valid", 32'(out_valid), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        release_out();
        seen = 0;
        repeat (STEPS + 3) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("bp_no_accept", 32'(seen), 32'd0);

        send(32'hA5A5_0F0F, 1'b0, model(32'hA5A5_0F0F, 1'b0));
        k = STEPS > 3 ? 3 : STEPS - 1;
        repeat (k) begin
            @(posedge clk);
            @(negedge clk);
        end
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        check("mid_rst_out", Out32, 32'h0);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd1);
        seen = 0;
        repeat (STEPS + 3) begin
            @(posedge clk);
            @(negedge clk);
            if (out_valid) seen++;
        end
        check("mid_rst_no_pulse", 32'(seen), 32'd0);
        send(32'h8000_0000, 1'b0, 32'h0100_0000);
        wait_done("post_rst");
        release_out();

`ifdef PBOX_BIDIR_EN
        send(32'h0000_8000, 1'b1, 32'h0000_0001);
        wait_done("fwd_bit");
        release_out();
        x = $urandom;
        send(x, 1'b1, model(x, 1'b1));
        wait_done("fwd_rand");
        release_out();
        send(model(x, 1'b1), 1'b0, x);
        wait_done("roundtrip");
        release_out();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
